// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 set-2 to CoCo keyboard matrix bridge.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_SKIP
  } dec_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_REQ, TX_WAIT
  } tx_state_e;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_AA = 8'hAA;
  localparam logic [7:0] CODE_FA = 8'hFA;
  localparam logic [7:0] CODE_FE = 8'hFE;
  localparam logic [7:0] CODE_00 = 8'h00;
  localparam logic [7:0] CODE_FF = 8'hFF;
  localparam logic [7:0] CODE_PRT1 = 8'h12;
  localparam logic [7:0] CODE_PRT2 = 8'h7C;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic key_pos_t kp(input logic [2:0] r, input logic [2:0] c);
    kp = '{valid: 1'b1, row: r, col: c};
  endfunction

endpackage

// File: rtl/ps2_scancode_lut.sv
// Combinational ROM: {extended, set-2 code} -> CoCo matrix position.
module ps2_scancode_lut
  import ps2_kbd_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output key_pos_t   pos_o
);

  always_comb begin
    // NOTE: default first so every path assigns pos_o and no latch is inferred.
    pos_o = '0;
    case ({ext_i, code_i})
      9'h054: pos_o = kp(3'd0, 3'd0);
      9'h01C: pos_o = kp(3'd0, 3'd1);
      9'h032: pos_o = kp(3'd0, 3'd2);
      9'h021: pos_o = kp(3'd0, 3'd3);
      9'h023: pos_o = kp(3'd0, 3'd4);
      9'h024: pos_o = kp(3'd0, 3'd5);
      9'h02B: pos_o = kp(3'd0, 3'd6);
      9'h034: pos_o = kp(3'd0, 3'd7);
      9'h033: pos_o = kp(3'd1, 3'd0);
      9'h043: pos_o = kp(3'd1, 3'd1);
      9'h03B: pos_o = kp(3'd1, 3'd2);
      9'h042: pos_o = kp(3'd1, 3'd3);
      9'h04B: pos_o = kp(3'd1, 3'd4);
      9'h03A: pos_o = kp(3'd1, 3'd5);
      9'h031: pos_o = kp(3'd1, 3'd6);
      9'h044: pos_o = kp(3'd1, 3'd7);
      9'h04D: pos_o = kp(3'd2, 3'd0);
      9'h015: pos_o = kp(3'd2, 3'd1);
      9'h02D: pos_o = kp(3'd2, 3'd2);
      9'h01B: pos_o = kp(3'd2, 3'd3);
      9'h02C: pos_o = kp(3'd2, 3'd4);
      9'h03C: pos_o = kp(3'd2, 3'd5);
      9'h02A: pos_o = kp(3'd2, 3'd6);
      9'h01D: pos_o = kp(3'd2, 3'd7);
      9'h022: pos_o = kp(3'd3, 3'd0);
      9'h035: pos_o = kp(3'd3, 3'd1);
      9'h01A: pos_o = kp(3'd3, 3'd2);
      9'h175: pos_o = kp(3'd3, 3'd3);
      9'h172: pos_o = kp(3'd3, 3'd4);
      9'h16B: pos_o = kp(3'd3, 3'd5);
      9'h174: pos_o = kp(3'd3, 3'd6);
      9'h029: pos_o = kp(3'd3, 3'd7);
      9'h045: pos_o = kp(3'd4, 3'd0);
      9'h016: pos_o = kp(3'd4, 3'd1);
      9'h01E: pos_o = kp(3'd4, 3'd2);
      9'h026: pos_o = kp(3'd4, 3'd3);
      9'h025: pos_o = kp(3'd4, 3'd4);
      9'h02E: pos_o = kp(3'd4, 3'd5);
      9'h036: pos_o = kp(3'd4, 3'd6);
      9'h03D: pos_o = kp(3'd4, 3'd7);
      9'h03E: pos_o = kp(3'd5, 3'd0);
      9'h046: pos_o = kp(3'd5, 3'd1);
      9'h052: pos_o = kp(3'd5, 3'd2);
      9'h04C: pos_o = kp(3'd5, 3'd3);
      9'h041: pos_o = kp(3'd5, 3'd4);
      9'h04E: pos_o = kp(3'd5, 3'd5);
      9'h049: pos_o = kp(3'd5, 3'd6);
      9'h04A: pos_o = kp(3'd5, 3'd7);
      9'h05A, 9'h15A: pos_o = kp(3'd6, 3'd0);
      9'h16C: pos_o = kp(3'd6, 3'd1);  // Home acts as CLEAR
      9'h076: pos_o = kp(3'd6, 3'd2);
      9'h011, 9'h111: pos_o = kp(3'd6, 3'd3);
      9'h014, 9'h114: pos_o = kp(3'd6, 3'd4);
      9'h005: pos_o = kp(3'd6, 3'd5);
      9'h006: pos_o = kp(3'd6, 3'd6);
      9'h012, 9'h059: pos_o = kp(3'd6, 3'd7);
      default: pos_o = '0;
    endcase
  end

endmodule

// File: rtl/ps2_kbd_matrix.sv
// PS/2 set-2 decoder driving a 7x8 CoCo keyboard matrix; PIA row sense readback.
// Optional keyboard reset command after rst is enabled with PS2_KBD_INIT_EN.
module ps2_kbd_matrix
  import ps2_kbd_pkg::*;
#(
  parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000,
  parameter logic [2:0]  SKIP_LEN       = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic [7:0] col_sel,
  output logic [6:0] row_out,
  output logic       kbd_reset_n
);

  dec_state_e       state_q;
  logic [15:0]      timer_q;
  logic [2:0]       skip_q;
  logic [6:0][7:0]  key_down_q;
  logic             prt_q;
  key_pos_t         pos;

  ps2_scancode_lut u_lut (
    .ext_i  (state_q == ST_EXT || state_q == ST_EXT_BRK),
    .code_i (rx_data),
    .pos_o  (pos)
  );

  // prt_q remembers that the last completed code was the E0 12 half of PrtScr.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the matrix is a flop array, not RAM, so it is cleared by reset.
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      skip_q      <= '0;
      key_down_q  <= '0;
      prt_q       <= 1'b0;
      kbd_reset_n <= 1'b1;
      row_out     <= 7'h7F;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from old values.
      kbd_reset_n <= 1'b1;
      for (int r = 0; r < 7; r++) row_out[r] <= ~|(key_down_q[r] & ~col_sel);
      if (state_q != ST_IDLE && timer_q != 16'd0) timer_q <= timer_q - 16'd1;

      if (rx_ready) begin
        case (state_q)
          ST_IDLE: begin
            if (!(rx_data inside {CODE_E0, CODE_F0, CODE_E1})) prt_q <= 1'b0;
            case (rx_data)
              CODE_E0: begin state_q <= ST_EXT; timer_q <= PREFIX_TIMEOUT; end
              CODE_F0: begin state_q <= ST_BRK; timer_q <= PREFIX_TIMEOUT; end
              CODE_E1: begin
                state_q <= ST_SKIP;
                timer_q <= PREFIX_TIMEOUT;
                skip_q  <= SKIP_LEN;
              end
              CODE_AA, CODE_00, CODE_FF: key_down_q <= '0;
              CODE_FA, CODE_FE: ;
              default: if (pos.valid) key_down_q[pos.row][pos.col] <= 1'b1;
            endcase
          end
          ST_EXT: begin
            if (rx_data == CODE_F0) begin
              state_q <= ST_EXT_BRK;
              timer_q <= PREFIX_TIMEOUT;
            end else begin
              if (pos.valid) key_down_q[pos.row][pos.col] <= 1'b1;
              if (rx_data == CODE_PRT2 && prt_q) kbd_reset_n <= 1'b0;
              prt_q   <= (rx_data == CODE_PRT1);
              state_q <= ST_IDLE;
            end
          end
          ST_BRK, ST_EXT_BRK: begin
            if (pos.valid) key_down_q[pos.row][pos.col] <= 1'b0;
            prt_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
          ST_SKIP: begin
            skip_q <= skip_q - 3'd1;
            prt_q  <= 1'b0;
            if (skip_q == 3'd1) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE && timer_q == 16'd0) begin
        state_q <= ST_IDLE;
      end
    end
  end

`ifdef PS2_KBD_INIT_EN
  tx_state_e   tx_state_q;
  logic [19:0] tx_timer_q;
  logic        tx_retry_q;
  logic        tx_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_timer_q <= '0;
      tx_retry_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_req     <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_req <= 1'b0;
          if (!tx_done_q) begin
            tx_done_q  <= 1'b1;
            tx_data    <= CODE_FF;
            tx_req     <= 1'b1;
            tx_state_q <= TX_REQ;
          end
        end
        TX_REQ: begin
          tx_req     <= 1'b0;
          tx_timer_q <= 20'hFFFFF;
          tx_state_q <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_ready) begin
            tx_state_q <= TX_IDLE;
          end else if (tx_timer_q == 20'd0) begin
            if (!tx_retry_q) begin
              tx_retry_q <= 1'b1;
              tx_req     <= 1'b1;
              tx_state_q <= TX_REQ;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_timer_q <= tx_timer_q - 20'd1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end
`else
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;
  assign tx_req  = 1'b0;
  assign tx_data = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Bench for ps2_kbd_matrix: directed sequences, a col_sel vector table and random bytes vs a model.
module tb_ps2_kbd_matrix;

  localparam int P = 64;

  logic       clk = 1'b0;
  logic       rst, rx_ready, tx_ready, tx_req, kbd_reset_n;
  logic [7:0] rx_data, tx_data, col_sel;
  logic [6:0] row_out;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_kbd_matrix #(.PREFIX_TIMEOUT(16'd64)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_req(tx_req),
    .col_sel(col_sel), .row_out(row_out), .kbd_reset_n(kbd_reset_n)
  );

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // {ext, code, row, col} one hex digit per field except the 8-bit code.
  localparam logic [19:0] MAP [60] = '{
    20'h05400, 20'h01C01, 20'h03202, 20'h02103, 20'h02304, 20'h02405, 20'h02B06, 20'h03407,
    20'h03310, 20'h04311, 20'h03B12, 20'h04213, 20'h04B14, 20'h03A15, 20'h03116, 20'h04417,
    20'h04D20, 20'h01521, 20'h02D22, 20'h01B23, 20'h02C24, 20'h03C25, 20'h02A26, 20'h01D27,
    20'h02230, 20'h03531, 20'h01A32, 20'h17533, 20'h17234, 20'h16B35, 20'h17436, 20'h02937,
    20'h04540, 20'h01641, 20'h01E42, 20'h02643, 20'h02544, 20'h02E45, 20'h03646, 20'h03D47,
    20'h03E50, 20'h04651, 20'h05252, 20'h04C53, 20'h04154, 20'h04E55, 20'h04956, 20'h04A57,
    20'h05A60, 20'h15A60, 20'h16C61, 20'h07662, 20'h01163, 20'h11163, 20'h01464, 20'h11464,
    20'h00565, 20'h00666, 20'h01267, 20'h05967
  };

  // Model: mode 0 idle, 1 after E0, 2 after F0, 3 after E0 F0, 4 skipping Pause bytes.
  bit m_key [7][8];
  int m_mode, m_entry, m_skip;
  bit m_prev_prt, m_pulse;

  function automatic void model_clear();
    foreach (m_key[r, c]) m_key[r][c] = 1'b0;
  endfunction

  function automatic void model_reset();
    model_clear();
    m_mode = 0; m_prev_prt = 0; m_pulse = 0;
  endfunction

  function automatic void lookup(input bit ext, input logic [7:0] code,
                                 output bit hit, output int r, output int c);
    hit = 0; r = 0; c = 0;
    foreach (MAP[i])
      if (MAP[i][19:16] == {3'b000, ext} && MAP[i][15:8] == code) begin
        hit = 1; r = int'(MAP[i][7:4]); c = int'(MAP[i][3:0]);
      end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int t);
    bit hit; int r, c;
    m_pulse = 0;
    if (m_mode != 0 && t > m_entry + P + 1) m_mode = 0;
    case (m_mode)
      0: begin
        if (b == 8'hE0) begin m_mode = 1; m_entry = t; end
        else if (b == 8'hF0) begin m_mode = 2; m_entry = t; end
        else if (b == 8'hE1) begin m_mode = 4; m_entry = t; m_skip = 7; end
        else begin
          m_prev_prt = 0;
          if (b == 8'hAA || b == 8'h00 || b == 8'hFF) model_clear();
          else if (b != 8'hFA && b != 8'hFE) begin
            lookup(0, b, hit, r, c);
            if (hit) m_key[r][c] = 1;
          end
        end
      end
      1: begin
        if (b == 8'hF0) begin m_mode = 3; m_entry = t; end
        else begin
          lookup(1, b, hit, r, c);
          if (hit) m_key[r][c] = 1;
          m_pulse = (b == 8'h7C) && m_prev_prt;
          m_prev_prt = (b == 8'h12);
          m_mode = 0;
        end
      end
      2, 3: begin
        lookup(m_mode == 3, b, hit, r, c);
        if (hit) m_key[r][c] = 0;
        m_prev_prt = 0; m_mode = 0;
      end
      default: begin
        m_skip--; m_prev_prt = 0;
        if (m_skip == 0) m_mode = 0;
      end
    endcase
  endfunction

  function automatic logic [6:0] model_rows(input logic [7:0] col);
    logic [6:0] rows = 7'h7F;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 8; c++)
        if (m_key[r][c] && !col[c]) rows[r] = 1'b0;
    return rows;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  logic last_krn;

  // Byte on one edge, then one idle edge with the new col_sel to read the rows back.
  task automatic send(input logic [7:0] b, input logic [7:0] col);
    rx_data = b; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    model_byte(b, cyc);
    last_krn = kbd_reset_n;
    check("kbd_reset_n", {7'd0, kbd_reset_n}, {7'd0, !m_pulse});
    col_sel = col;
    tick();
    check("row_out", {1'b0, row_out}, {1'b0, model_rows(col)});
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
  endtask

  typedef struct { logic [7:0] col; logic [6:0] exp; } vec_t;
  vec_t vecs[8];

  localparam logic [7:0] POOL [20] = '{
    8'h1C, 8'h1A, 8'h12, 8'h59, 8'h75, 8'h72, 8'h7C, 8'hE0, 8'hE0, 8'hF0,
    8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h29, 8'h14, 8'h5A, 8'h6C, 8'h76, 8'h05
  };

  initial begin
    // Keys held for the table: A r0c1, Up r3c3, LShift r6c7, 0 r4c0.
    vecs[0] = '{8'hFF, 7'h7F};
    vecs[1] = '{8'hFD, 7'h7E};
    vecs[2] = '{8'hF7, 7'h77};
    vecs[3] = '{8'h7F, 7'h3F};
    vecs[4] = '{8'hFE, 7'h6F};
    vecs[5] = '{8'h00, 7'h26};
    vecs[6] = '{8'hF5, 7'h76};
    vecs[7] = '{8'h7E, 7'h2F};

    rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; col_sel = 8'hFF;
    model_reset();
    idle(2);
    check("reset row_out", {1'b0, row_out}, 8'h7F);
    check("reset kbd_reset_n", {7'd0, kbd_reset_n}, 8'h01);
    check("reset tx_req", {7'd0, tx_req}, 8'h00);
    check("reset tx_data", tx_data, 8'h00);
    rst = 1'b0;

`ifdef PS2_KBD_INIT_EN
    begin
      int pulses = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (tx_req) begin
          pulses++;
          check("init tx_data", tx_data, 8'hFF);
        end
      end
      check("init tx_data held", tx_data, 8'hFF);
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (tx_req) pulses++;
      end
      check("init tx_req pulses", pulses[7:0], 8'd1);
    end
`endif

    // A make/break.
    send(8'h1C, 8'hFD); check("A make", {1'b0, row_out}, 8'h7E);
    send(8'hF0, 8'hFD); send(8'h1C, 8'hFD); check("A break", {1'b0, row_out}, 8'h7F);

    // Extended Up make/break.
    send(8'hE0, 8'hF7); send(8'h75, 8'hF7); check("Up make", {1'b0, row_out}, 8'h77);
    send(8'hE0, 8'hF7); send(8'hF0, 8'hF7); send(8'h75, 8'hF7);
    check("Up break", {1'b0, row_out}, 8'h7F);

    // Both shifts share one cell; the first break clears it.
    send(8'h12, 8'h7F); send(8'h59, 8'h7F); check("shift held", {1'b0, row_out}, 8'h3F);
    send(8'hF0, 8'h7F); send(8'h12, 8'h7F); check("shift break", {1'b0, row_out}, 8'h7F);

    // Prefix expired one cycle before the byte: 1C decodes as a normal A.
    send(8'hE0, 8'hFF); idle(P); send(8'h1C, 8'hFD);
    check("timeout A", {1'b0, row_out}, 8'h7E);
    send(8'hF0, 8'hFD); send(8'h1C, 8'hFD);
    // Byte on the very cycle the timer reaches zero still counts as extended.
    send(8'hE0, 8'hFF); idle(P - 1); send(8'h75, 8'hF7);
    check("timeout edge Up", {1'b0, row_out}, 8'h77);
    send(8'hE0, 8'hF7); send(8'hF0, 8'hF7); send(8'h75, 8'hF7);

    // BAT clears everything; Pause sequence is swallowed.
    send(8'h1C, 8'h00); send(8'h1A, 8'h00); check("A Z held", {1'b0, row_out}, 8'h76);
    send(8'hAA, 8'h00); check("BAT clear", {1'b0, row_out}, 8'h7F);
    foreach (POOL[i]) if (i < 0) $display("unreachable");
    send(8'hE1, 8'h00); send(8'h14, 8'h00); send(8'h77, 8'h00); send(8'hE1, 8'h00);
    send(8'hF0, 8'h00); send(8'h14, 8'h00); send(8'hF0, 8'h00); send(8'h77, 8'h00);
    check("pause skipped", {1'b0, row_out}, 8'h7F);
    send(8'h1C, 8'hFD); check("A after pause", {1'b0, row_out}, 8'h7E);

    // PrtScr make requests a soft reset.
    send(8'hE0, 8'hFF); send(8'h12, 8'hFF); send(8'hE0, 8'hFF); send(8'h7C, 8'hFF);
    check("prtscr pulse", {7'd0, last_krn}, 8'h00);
    check("prtscr one cycle", {7'd0, kbd_reset_n}, 8'h01);

    // Reset mid-prefix clears the matrix and the pending E0.
    send(8'hE0, 8'h00);
    rst = 1'b1; tick();
    check("rst row_out", {1'b0, row_out}, 8'h7F);
    rst = 1'b0; model_reset();
    send(8'h75, 8'h00); check("rst drops prefix", {1'b0, row_out}, 8'h7F);

    // Column table with four keys held.
    do_reset();
    send(8'h1C, 8'hFF); send(8'hE0, 8'hFF); send(8'h75, 8'hFF);
    send(8'h12, 8'hFF); send(8'h45, 8'hFF);
    foreach (vecs[i]) begin
      col_sel = vecs[i].col;
      tick();
      check($sformatf("table col %h", vecs[i].col), {1'b0, row_out}, {1'b0, vecs[i].exp});
    end

    // Random bytes against the model, including prefix-timeout boundaries.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      int gap;
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : POOL[$urandom_range(0, 19)];
      send(b, 8'($urandom));
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(P - 2, P + 2) : $urandom_range(0, 3);
      idle(gap);
`ifndef PS2_KBD_INIT_EN
      if (i % 50 == 0) begin
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        check("tx_req idle", {7'd0, tx_req}, 8'h00);
        check("tx_data idle", tx_data, 8'h00);
      end
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
